// File: rtl/alu_seq_param.sv
// Sequential, parametrised ALU with a start/busy/done handshake and multi-cycle shifts by N.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 0100).
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_start,
  input  logic [3:0]       alu_select,
  input  logic [WIDTH-1:0] alu_a_in,
  input  logic [WIDTH-1:0] alu_b_in,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             alu_carry_out,
  output logic             alu_zero_flag,
  output logic             alu_busy,
  output logic             alu_done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_SHFR = 4'b1011;
  localparam logic [3:0] OP_SHFL = 4'b1100;
  localparam logic [3:0] OP_SHLN = 4'b1101;
  localparam logic [3:0] OP_SHRN = 4'b1110;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b0100;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic [SHW-1:0]   shift_n;
  logic             is_shn;
  logic             is_mul;
  logic             go_run;
  logic [WIDTH:0]   sc_res;
  logic             sc_valid;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    cnt_q;
  logic             run_left_q;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] step_hi;
  logic             step_carry;

  assign accept  = alu_start && (state_q != RUN);
  assign shift_n = alu_b_in[SHW-1:0];
  assign is_shn  = (alu_select == OP_SHLN) || (alu_select == OP_SHRN);
`ifdef ALU_MUL_EN
  assign is_mul  = (alu_select == OP_MUL);
`else
  assign is_mul  = 1'b0;
`endif
  assign go_run  = is_mul || (is_shn && (shift_n != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    alu_busy = 1'b0;
    alu_done = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        alu_done = (state_q == DONE);
        if (accept) state_d = go_run ? RUN : DONE;
        else        state_d = IDLE;
      end
      RUN: begin
        alu_busy = 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle result: bit WIDTH is carry/borrow; n=0 shifts pass A through.
  always_comb begin
    sc_res   = '0;
    sc_valid = 1'b1;
    case (alu_select)
      OP_ADD:          sc_res = {1'b0, alu_a_in} + {1'b0, alu_b_in};
      OP_SUB:          sc_res = {1'b0, alu_a_in} - {1'b0, alu_b_in};
      OP_NOR:          sc_res = {1'b0, ~(alu_a_in | alu_b_in)};
      OP_SHFL:         sc_res = {alu_a_in, 1'b0};
      OP_SHFR:         sc_res = {2'b00, alu_a_in[WIDTH-1:1]};
      OP_SHLN, OP_SHRN: sc_res = {1'b0, alu_a_in};
      OP_NOP:          sc_valid = 1'b0;
      default:         sc_valid = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] out_hi_q;
  logic             run_mul_q;
  logic [WIDTH:0]   prod_sum;
  assign prod_sum   = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
  assign alu_out_hi = out_hi_q;
`else
  assign alu_out_hi = '0;
`endif

  // One iteration per RUN cycle; the multiplier keeps {hi, multiplier} as one right-shifting pair.
  always_comb begin
    step_hi = '0;
    if (run_left_q) begin
      step_lo    = {work_q[WIDTH-2:0], 1'b0};
      step_carry = work_q[WIDTH-1];
    end else begin
      step_lo    = {1'b0, work_q[WIDTH-1:1]};
      step_carry = work_q[0];
    end
`ifdef ALU_MUL_EN
    if (run_mul_q) begin
      {step_hi, step_lo} = {prod_sum, work_q[WIDTH-1:1]};
      step_carry         = |step_hi;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q        <= '0;
      cnt_q         <= '0;
      run_left_q    <= 1'b0;
      alu_out       <= '0;
      alu_carry_out <= 1'b0;
      alu_zero_flag <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q          <= '0;
      mcand_q       <= '0;
      out_hi_q      <= '0;
      run_mul_q     <= 1'b0;
`endif
    end else if (state_q == RUN) begin
      work_q <= step_lo;
      cnt_q  <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
      hi_q   <= step_hi;
`endif
      if (cnt_q == CW'(1)) begin
        alu_out       <= step_lo;
        alu_carry_out <= step_carry;
        alu_zero_flag <= ~|{step_carry, step_lo};
`ifdef ALU_MUL_EN
        out_hi_q      <= run_mul_q ? step_hi : '0;
`endif
      end
    end else if (accept) begin
      run_left_q <= (alu_select == OP_SHLN);
      work_q     <= is_mul ? alu_b_in : alu_a_in;
      cnt_q      <= is_mul ? CW'(WIDTH) : CW'(shift_n);
`ifdef ALU_MUL_EN
      run_mul_q  <= is_mul;
      hi_q       <= '0;
      mcand_q    <= alu_a_in;
`endif
      if (!go_run) begin
        alu_out       <= sc_res[WIDTH-1:0];
        alu_carry_out <= sc_res[WIDTH];
        alu_zero_flag <= sc_valid && (sc_res == '0);
`ifdef ALU_MUL_EN
        out_hi_q      <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: WIDTH=8 and WIDTH=16 instances against a transaction-level model.
// Expectations for opcode 0100 follow ALU_MUL_EN when it is defined.
module tb_alu_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        start [2];
  logic [3:0]  sel   [2];
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [7:0]  out8, hi8;
  logic [15:0] out16, hi16;
  logic        carry8, zero8, busy8, done8;
  logic        carry16, zero16, busy16, done16;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  alu_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n[0]), .alu_start(start[0]), .alu_select(sel[0]),
    .alu_a_in(a8), .alu_b_in(b8), .alu_out(out8), .alu_out_hi(hi8),
    .alu_carry_out(carry8), .alu_zero_flag(zero8), .alu_busy(busy8), .alu_done(done8)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n[1]), .alu_start(start[1]), .alu_select(sel[1]),
    .alu_a_in(a16), .alu_b_in(b16), .alu_out(out16), .alu_out_hi(hi16),
    .alu_carry_out(carry16), .alu_zero_flag(zero16), .alu_busy(busy16), .alu_done(done16)
  );

  function automatic logic [31:0] get_out(input int i);
    return (i == 0) ? {24'h0, out8} : {16'h0, out16};
  endfunction
  function automatic logic [31:0] get_hi(input int i);
    return (i == 0) ? {24'h0, hi8} : {16'h0, hi16};
  endfunction
  function automatic logic get_carry(input int i);
    return (i == 0) ? carry8 : carry16;
  endfunction
  function automatic logic get_zero(input int i);
    return (i == 0) ? zero8 : zero16;
  endfunction
  function automatic logic get_busy(input int i);
    return (i == 0) ? busy8 : busy16;
  endfunction
  function automatic logic get_done(input int i);
    return (i == 0) ? done8 : done16;
  endfunction

  task automatic check_output(input string name, input int i, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (dut%0d): got %0h required %0h", name, i, act, exp);
    end
  endtask

  // Whole-operation result and latency from plain arithmetic; w is a power of two here,
  // so the shift count field is simply B mod w.
  function automatic void compute(input int w, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] o,
                                  output logic [31:0] h, output logic c, output logic z,
                                  output int lat);
    longint unsigned mask, av, bv, r;
    int n;
    bit valid;
    mask = (64'd1 << w) - 64'd1;
    av = 64'(a) & mask;
    bv = 64'(b) & mask;
    n = int'(bv % 64'(w));
    r = 0; c = 1'b0; h = '0; lat = 1; valid = 1'b1;
    case (op)
      4'h1: begin r = av + bv; c = ((r >> w) & 64'd1) != 0; end
      4'h2: begin r = av - bv; c = (av < bv); end
      4'h3: r = ~(av | bv);
`ifdef ALU_MUL_EN
      4'h4: begin r = av * bv; h = 32'((r >> w) & mask); c = (h != 0); lat = w + 1; end
`endif
      4'hB: r = av >> 1;
      4'hC: begin r = av << 1; c = ((av >> (w - 1)) & 64'd1) != 0; end
      4'hD: begin
        r = av << n;
        if (n > 0) begin c = ((av >> (w - n)) & 64'd1) != 0; lat = n + 1; end
      end
      4'hE: begin
        r = av >> n;
        if (n > 0) begin c = ((av >> (n - 1)) & 64'd1) != 0; lat = n + 1; end
      end
      default: valid = 1'b0;
    endcase
    o = 32'(r & mask);
    z = valid && (o == 0) && !c;
  endfunction

  logic [31:0] m_out [2], m_hi [2], p_out [2], p_hi [2];
  logic        m_carry [2], m_zero [2], m_busy [2], m_done [2], p_carry [2], p_zero [2];
  int          m_rem [2];

  always @(posedge clk) begin : model_blk
    logic [31:0] o, h;
    logic c, z;
    int lat;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        m_out[i] <= '0; m_hi[i] <= '0; m_carry[i] <= 1'b0; m_zero[i] <= 1'b0;
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_rem[i] <= 0;
      end else if (m_rem[i] > 0) begin
        m_rem[i] <= m_rem[i] - 1;
        if (m_rem[i] == 1) begin
          m_out[i] <= p_out[i]; m_hi[i] <= p_hi[i];
          m_carry[i] <= p_carry[i]; m_zero[i] <= p_zero[i];
          m_busy[i] <= 1'b0; m_done[i] <= 1'b1;
        end else begin
          m_busy[i] <= 1'b1; m_done[i] <= 1'b0;
        end
      end else if (start[i]) begin
        compute((i == 0) ? 8 : 16, sel[i], (i == 0) ? {24'h0, a8} : {16'h0, a16},
                (i == 0) ? {24'h0, b8} : {16'h0, b16}, o, h, c, z, lat);
        if (lat == 1) begin
          m_out[i] <= o; m_hi[i] <= h; m_carry[i] <= c; m_zero[i] <= z;
          m_busy[i] <= 1'b0; m_done[i] <= 1'b1;
        end else begin
          p_out[i] <= o; p_hi[i] <= h; p_carry[i] <= c; p_zero[i] <= z;
          m_rem[i] <= lat - 1; m_busy[i] <= 1'b1; m_done[i] <= 1'b0;
        end
      end else begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check_output("cyc_busy",  i, 32'(get_busy(i)),  32'(m_busy[i]));
        check_output("cyc_done",  i, 32'(get_done(i)),  32'(m_done[i]));
        check_output("cyc_out",   i, get_out(i),        m_out[i]);
        check_output("cyc_hi",    i, get_hi(i),         m_hi[i]);
        check_output("cyc_carry", i, 32'(get_carry(i)), 32'(m_carry[i]));
        check_output("cyc_zero",  i, 32'(get_zero(i)),  32'(m_zero[i]));
      end
    end
  end

  task automatic apply_stimulus(input int i, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    sel[i] = op;
    if (i == 0) begin a8 = a[7:0]; b8 = b[7:0]; end
    else begin a16 = a[15:0]; b16 = b[15:0]; end
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string name, input int first, input int exp_lat);
    int lat;
    lat = first;
    while (!get_done(i) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_output({name, "_latency"}, i, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_result(input int i, input string name, input logic [31:0] o,
                              input logic c, input logic z);
    check_output({name, "_out"},   i, get_out(i),        o);
    check_output({name, "_carry"}, i, 32'(get_carry(i)), 32'(c));
    check_output({name, "_zero"},  i, 32'(get_zero(i)),  32'(z));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; sel[i] = 4'h0;
    end
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_result(i, "reset", 32'h0, 1'b0, 1'b0);
      check_output("reset_busy", i, 32'(get_busy(i)), 32'h0);
      check_output("reset_done", i, 32'(get_done(i)), 32'h0);
      rst_n[i] = 1'b1;
    end
    @(negedge clk);

    apply_stimulus(0, 4'h1, 32'hFF, 32'h01);
    wait_done(0, "add_ff", 1, 1);
    check_result(0, "add_ff", 32'h00, 1'b1, 1'b0);
    apply_stimulus(0, 4'h1, 32'h00, 32'h00);
    wait_done(0, "add_00", 1, 1);
    check_result(0, "add_00", 32'h00, 1'b0, 1'b1);

    apply_stimulus(0, 4'h2, 32'h03, 32'h05);
    wait_done(0, "sub_borrow", 1, 1);
    check_result(0, "sub_borrow", 32'hFE, 1'b1, 1'b0);

    apply_stimulus(0, 4'hC, 32'h81, 32'h00);
    wait_done(0, "shfl", 1, 1);
    check_result(0, "shfl", 32'h02, 1'b1, 1'b0);
    apply_stimulus(0, 4'hB, 32'h81, 32'h00);
    wait_done(0, "shfr", 1, 1);
    check_result(0, "shfr", 32'h40, 1'b0, 1'b0);
    apply_stimulus(0, 4'h7, 32'hFF, 32'hFF);
    wait_done(0, "default_op", 1, 1);
    check_result(0, "default_op", 32'h00, 1'b0, 1'b0);
    @(negedge clk);

    // SHLN by 3 with a second start issued while busy, which must be dropped
    apply_stimulus(0, 4'hD, 32'hB1, 32'h03);
    check_output("shln3_busy_t1", 0, 32'(get_busy(0)), 32'h1);
    sel[0] = 4'h1; a8 = 8'h11; b8 = 8'h22; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check_output("shln3_busy_t2", 0, 32'(get_busy(0)), 32'h1);
    wait_done(0, "shln3", 2, 4);
    check_result(0, "shln3", 32'h88, 1'b1, 1'b0);
    @(negedge clk);
    check_output("shln3_no_queue", 0, 32'(get_done(0)), 32'h0);

    apply_stimulus(0, 4'hE, 32'h5A, 32'h08);
    wait_done(0, "shrn0", 1, 1);
    check_result(0, "shrn0", 32'h5A, 1'b0, 1'b0);
    apply_stimulus(0, 4'h3, 32'hF0, 32'h0F);
    check_output("b2b_done", 0, 32'(get_done(0)), 32'h1);
    check_result(0, "b2b_nor", 32'h00, 1'b0, 1'b1);
    @(negedge clk);
    check_output("b2b_done_drop", 0, 32'(get_done(0)), 32'h0);

    apply_stimulus(0, 4'h4, 32'hFF, 32'hFF);
`ifdef ALU_MUL_EN
    wait_done(0, "mul", 1, 9);
    check_result(0, "mul", 32'h01, 1'b1, 1'b0);
    check_output("mul_hi", 0, get_hi(0), 32'hFE);
`else
    wait_done(0, "mul", 1, 1);
    check_result(0, "mul", 32'h00, 1'b0, 1'b0);
    check_output("mul_hi", 0, get_hi(0), 32'h00);
`endif
    @(negedge clk);

    apply_stimulus(1, 4'h1, 32'h1234, 32'h1111);
    wait_done(1, "add16", 1, 1);
    check_result(1, "add16", 32'h2345, 1'b0, 1'b0);
    apply_stimulus(1, 4'hE, 32'h8001, 32'h0001);
    wait_done(1, "shrn1", 1, 2);
    check_result(1, "shrn1", 32'h4000, 1'b1, 1'b0);
    @(negedge clk);

    // Abort a 10-step shift with reset part-way through
    apply_stimulus(1, 4'hD, 32'h00FF, 32'h000A);
    check_output("abort_busy", 1, 32'(get_busy(1)), 32'h1);
    repeat (3) @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    check_output("abort_busy_clr", 1, 32'(get_busy(1)), 32'h0);
    check_output("abort_done_clr", 1, 32'(get_done(1)), 32'h0);
    check_result(1, "abort", 32'h0, 1'b0, 1'b0);
    rst_n[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_output("abort_no_done", 1, 32'(get_done(1)), 32'h0);
    end
    apply_stimulus(1, 4'h1, 32'hFFFF, 32'h0001);
    wait_done(1, "add16_wrap", 1, 1);
    check_result(1, "add16_wrap", 32'h0000, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_seq_param.md
# alu_seq_param

Parametrised, sequential successor to the team's 8-bit combinational ALU.
- Keeps the existing opcode map (NOP/ADD/SUB/NOR/SHFL/SHFR) and flag semantics.
- Adds registered outputs, a start/busy/done handshake, and multi-cycle barrel-free shifts by N.
- Adds an optional iterative shift-add multiplier.
- Sits between the controller FSM (select/start/done/flags) and the ACC input mux (alu_out).

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW (localparam), $clog2(WIDTH), width of the shift-count field taken from alu_b_in[SHW-1:0].
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- alu_start  input  1  request; accepted on a rising edge when alu_start=1 and alu_busy=0.
- alu_select  input  4  opcode, sampled at acceptance.
- alu_a_in  input  WIDTH  ACC operand, sampled at acceptance.
- alu_b_in  input  WIDTH  REG operand, sampled at acceptance.
- alu_out  output  WIDTH  registered result (low half for MUL).
- alu_out_hi  output  WIDTH  high half of MUL product; 0 for every other op.
- alu_carry_out  output  1  registered carry/borrow/shifted-out bit.
- alu_zero_flag  output  1  registered; 1 iff {alu_carry_out, alu_out}==0 for the completed op.
- alu_busy  output  1  high while a multi-cycle op is in RUN.
- alu_done  output  1  one-cycle pulse; result and flags are valid from this cycle onward.

## Operation
- Opcodes:
  - NOP=0000
  - ADD=0001
  - SUB=0010
  - NOR=0011
  - MUL=0100
  - SHFR=1011
  - SHFL=1100
  - SHLN=1101
  - SHRN=1110
  - all others are treated as default.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
  - IDLE/DONE + accepted single-cycle op → DONE.
  - IDLE/DONE + accepted multi-cycle op with count>0 → RUN.
  - RUN + count reaches 0 → DONE.
  - DONE with no accept → IDLE.
  - alu_busy=1 only in RUN. alu_done=1 only in DONE.
- ADD: {carry,out} = A+B, computed at WIDTH+1 bits.
- SUB: {carry,out} = A−B at WIDTH+1 bits. carry=1 means borrow.
- NOR: out = ~(A|B), carry = 0.
- SHFL: {carry,out} = {A,1'b0}.
- SHFR: out = A>>1, carry = 0.
- SHLN/SHRN: n = B[SHW-1:0].
  - One 1-bit shift per RUN cycle, zero fill.
  - carry = last bit shifted out.
  - n=0 → out=A, carry=0, completes as a single-cycle op.
- MUL: unsigned A×B by shift-add, WIDTH iterations. {alu_out_hi, alu_out} = product; carry = |alu_out_hi.
- NOP/default: out=0, hi=0, carry=0, zero=0. alu_done still pulses.
- Outputs hold their last completed value until the next op completes. Intermediate RUN values are never visible on the outputs.
- alu_start while busy is ignored and not queued.

## Timing
- Reset (rst_n=0 at an edge): all outputs 0, state IDLE.
  - Reset during RUN aborts the op. The next cycle shows busy=0, done=0, outputs 0.
- Accept edge = T0.
- Single-cycle ops, and SHLN/SHRN with n=0: done=1 in cycle T0+1.
- SHLN/SHRN with n>0: busy=1 for cycles T0+1..T0+n; done=1 at T0+n+1.
- MUL: busy=1 for cycles T0+1..T0+WIDTH; done=1 at T0+WIDTH+1.
- Back-to-back: a start during the DONE cycle is accepted. For a single-cycle op this gives one op per cycle, with done staying high continuously.
- Flags update on the same edge as alu_out.

## Configuration
- ALU_MUL_EN:
  - Defined: MUL is implemented as above and alu_out_hi is driven.
  - Undefined: no multiplier datapath is synthesised, opcode 0100 behaves as default (latency 1), and alu_out_hi is tied to 0.

## Test plan
- Reset and ADD, WIDTH=8: hold rst_n=0, then start ADD with A=0xFF, B=0x01. Expect done at T0+1 with out=0x00, carry=1, zero=0. Then A=0x00, B=0x00 gives zero=1.
- SUB borrow: A=0x03, B=0x05. Expect out=0xFE, carry=1, done at T0+1.
- SHLN, n=3: A=0xB1, B=0x03.
  - Expect busy during T0+1..T0+3 and done at T0+4.
  - Expect out=0x88, carry=1 (last bit out is A[5]=1).
  - A start pulsed during busy is ignored.
- SHRN, n=0: A=0x5A, B=0x08, so B[2:0]=0. Expect out=0x5A, carry=0, done at T0+1. Then back-to-back NOR A=0xF0, B=0x0F in the DONE cycle gives out=0x00, zero=1, done high for two consecutive cycles.
- MUL with ALU_MUL_EN: A=0xFF, B=0xFF. Expect done at T0+9, out=0x01, hi=0xFE, carry=1. Without the macro, expect done at T0+1 with all outputs 0.
- Reset mid-op and WIDTH=16: drop rst_n during SHLN n=10. Expect busy=0 and outputs 0 next cycle, and no done pulse. Then ADD A=0xFFFF, B=0x0001 gives out=0x0000, carry=1.
